uart_rx_frame: RTL and testbench

Parametrised UART receiver for the oscilloscope's host command link. It replaces the fixed 8N1 receive path with one configurable in clocks-per-bit, data width, parity and stop bits. It adds majority-vote sampling, false-start rejection, error flags and a valid/ready output holding register. It sits between the `uart_rx` pin and the command decoder.

---
 rtl/uart_rx_frame.sv | 157 +++++++++++++++
 tb/tb_uart_rx_frame.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame.sv
// Configurable UART receiver: 2-flop synchronizer, 3-sample majority vote per bit,
// optional parity, 1-2 stop bits, false-start rejection and a valid/ready holding register.
module uart_rx_frame #(
    parameter int unsigned CLKS_PER_BIT = 8,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 uart_rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_perr,
    output logic                 frame_err,
    output logic                 overrun,
    input  logic                 err_clr
);

    localparam int unsigned H  = CLKS_PER_BIT / 2;
    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] C_S0   = CW'(H - 1);
    localparam logic [CW-1:0] C_S1   = CW'(H);
    localparam logic [CW-1:0] C_DEC  = CW'(H + 1);
    localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]    C_DLAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    C_SLAST = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_BREAK
    } state_t;

    state_t               r_state, w_next;
    logic [1:0]           r_sync;
    logic [CW-1:0]        r_cnt;
    logic [1:0]           r_smp;
    logic [3:0]           r_bit;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par;
    logic                 r_perr_pend;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_perr;
    logic                 r_ferr;
    logic                 r_ovr;
    logic                 w_rx_s;
    logic                 w_dec;
    logic                 w_maj;
    logic                 w_deliver;
    logic                 w_ferr;
    logic                 w_load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_sync <= '1;
        else        r_sync <= {r_sync[0], uart_rx};
    end

    assign w_rx_s = r_sync[1];
    assign w_dec  = (r_cnt == C_DEC) && (r_state != S_IDLE) && (r_state != S_BREAK);
    assign w_maj  = (r_smp[0] & r_smp[1]) | (r_smp[0] & w_rx_s) | (r_smp[1] & w_rx_s);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (!w_rx_s) w_next = S_START;
            S_START: if (w_dec) w_next = w_maj ? S_IDLE : S_DATA;
            S_DATA:  if (w_dec && r_bit == C_DLAST) w_next = (PARITY != 0) ? S_PAR : S_STOP;
            S_PAR:   if (w_dec) w_next = S_STOP;
            S_STOP: begin
                if (w_dec) begin
                    if (!w_maj)               w_next = S_BREAK;
                    else if (r_bit == C_SLAST) w_next = S_IDLE;
                end
            end
            S_BREAK: if (w_rx_s) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_deliver = 1'b0;
        w_ferr    = 1'b0;
        if (r_state == S_STOP && w_dec) begin
            w_deliver = w_maj && (r_bit == C_SLAST);
            w_ferr    = !w_maj;
        end
    end

    // cnt is loaded with 1 on start detection so the detect cycle itself counts as cnt = 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_smp       <= '1;
            r_bit       <= '0;
            r_shift     <= '0;
            r_par       <= 1'b0;
            r_perr_pend <= 1'b0;
        end else begin
            if (r_state == S_IDLE || r_state == S_BREAK)
                r_cnt <= (r_state == S_IDLE && !w_rx_s) ? CW'(1) : '0;
            else
                r_cnt <= (r_cnt == C_LAST) ? '0 : r_cnt + CW'(1);
            if (r_cnt == C_S0) r_smp[0] <= w_rx_s;
            if (r_cnt == C_S1) r_smp[1] <= w_rx_s;
            if (r_state == S_IDLE) begin
                r_bit       <= '0;
                r_par       <= 1'b0;
                r_perr_pend <= 1'b0;
            end
            if (w_dec) begin
                r_bit <= (w_next != r_state) ? '0 : r_bit + 4'd1;
                if (r_state == S_DATA) begin
                    r_shift <= {w_maj, r_shift[DATA_BITS-1:1]};
                    r_par   <= r_par ^ w_maj;
                end
                if (r_state == S_PAR)
                    r_perr_pend <= (PARITY == 1) ? ~(r_par ^ w_maj) : (r_par ^ w_maj);
            end
        end
    end

    assign w_load = w_deliver && (!r_valid || rx_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_perr  <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            if (w_load) begin
                r_data  <= r_shift;
                r_perr  <= r_perr_pend;
                r_valid <= 1'b1;
            end else if (rx_ready) begin
                r_valid <= 1'b0;
            end
            r_ferr <= w_ferr;
            if (w_deliver && r_valid && !rx_ready) r_ovr <= 1'b1;
            else if (err_clr)                      r_ovr <= 1'b0;
        end
    end

    assign rx_data   = r_data;
    assign rx_valid  = r_valid;
    assign rx_perr   = r_perr;
    assign frame_err = r_ferr;
    assign overrun   = r_ovr;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame: a default 8N1 instance and an even-parity, 16 clocks/bit
// instance, with expected words queued at send time and checked when handed over.
module tb_uart_rx_frame;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       d_rx, d_ready, d_eclr;
    logic [7:0] d_data;
    logic       d_valid, d_perr, d_ferr, d_ovr;
    logic       p_rx, p_ready, p_eclr;
    logic [7:0] p_data;
    logic       p_valid, p_perr, p_ferr, p_ovr;

    uart_rx_frame u_dut (
        .clk(clk), .rst_n(rst_n), .uart_rx(d_rx),
        .rx_data(d_data), .rx_valid(d_valid), .rx_ready(d_ready),
        .rx_perr(d_perr), .frame_err(d_ferr), .overrun(d_ovr), .err_clr(d_eclr)
    );

    uart_rx_frame #(.CLKS_PER_BIT(16), .PARITY(2)) u_par (
        .clk(clk), .rst_n(rst_n), .uart_rx(p_rx),
        .rx_data(p_data), .rx_valid(p_valid), .rx_ready(p_ready),
        .rx_perr(p_perr), .frame_err(p_ferr), .overrun(p_ovr), .err_clr(p_eclr)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    logic [8:0] d_q[$];
    logic [8:0] p_q[$];
    int   d_vcyc = 0, d_fcnt = 0, d_rise = -1, p_got = 0, p_fcnt = 0;
    logic d_prev = 1'b0;
    int   t0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [8:0] e;
        if (d_valid && !d_prev) d_rise = cyc;
        if (d_valid) d_vcyc++;
        if (d_ferr) d_fcnt++;
        if (d_valid && d_ready) begin
            if (d_q.size() == 0) begin
                vectors++;
                miscompares++;
                $error("FAIL d_word: observed %0h expected none", {d_perr, d_data});
            end else begin
                e = d_q.pop_front();
                chk("d_word", 32'({d_perr, d_data}), 32'(e));
            end
        end
        d_prev = d_valid;
        if (p_ferr) p_fcnt++;
        if (p_valid && p_ready) begin
            p_got++;
            if (p_q.size() == 0) begin
                vectors++;
                miscompares++;
                $error("FAIL p_word: observed %0h expected none", {p_perr, p_data});
            end else begin
                e = p_q.pop_front();
                chk("p_word", 32'({p_perr, p_data}), 32'(e));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic d_bit(input logic b);
        d_rx = b;
        tick(8);
    endtask

    task automatic d_frame(input logic [7:0] v, input logic stop);
        d_bit(1'b0);
        for (int i = 0; i < 8; i++) d_bit(v[i]);
        d_bit(stop);
    endtask

    task automatic p_bit(input logic b);
        p_rx = b;
        tick(16);
    endtask

    task automatic p_frame(input logic [7:0] v, input logic par);
        p_bit(1'b0);
        for (int i = 0; i < 8; i++) p_bit(v[i]);
        p_bit(par);
        p_bit(1'b1);
    endtask

    initial begin
        rst_n = 1'b0;
        d_rx = 1'b1; d_ready = 1'b1; d_eclr = 1'b0;
        p_rx = 1'b1; p_ready = 1'b1; p_eclr = 1'b0;
        tick(3);
        chk("rst_data", 32'(d_data), 32'h0);
        chk("rst_valid", 32'(d_valid), 32'h0);
        chk("rst_perr", 32'(d_perr), 32'h0);
        chk("rst_ferr", 32'(d_ferr), 32'h0);
        chk("rst_ovr", 32'(d_ovr), 32'h0);
        chk("rst_p_valid", 32'(p_valid), 32'h0);
        rst_n = 1'b1;
        tick(4);

        // 0x61 at 8 clocks/bit: valid at cycle 78 = 80 clocks after the pin falls
        d_vcyc = 0; d_rise = -1;
        d_q.push_back({1'b0, 8'h61});
        t0 = cyc;
        d_frame(8'h61, 1'b1);
        tick(16);
        chk("lat_61", 32'(d_rise - t0), 32'd80);
        chk("vlen_61", 32'(d_vcyc), 32'd1);
        chk("q_61", 32'(d_q.size()), 32'd0);

        // 3-clock glitch is a false start
        d_vcyc = 0; d_fcnt = 0;
        d_rx = 1'b0; tick(3);
        d_rx = 1'b1; tick(24);
        chk("fs_valid", 32'(d_vcyc), 32'd0);
        chk("fs_ferr", 32'(d_fcnt), 32'd0);
        d_rise = -1;
        d_q.push_back({1'b0, 8'h3C});
        t0 = cyc;
        d_frame(8'h3C, 1'b1);
        tick(16);
        chk("lat_3c", 32'(d_rise - t0), 32'd80);
        chk("q_3c", 32'(d_q.size()), 32'd0);

        // even parity: 0x55 has even weight
        p_q.push_back({1'b0, 8'h55});
        p_frame(8'h55, 1'b0);
        p_q.push_back({1'b1, 8'h55});
        p_frame(8'h55, 1'b1);
        tick(32);
        chk("p_got", 32'(p_got), 32'd2);
        chk("p_q", 32'(p_q.size()), 32'd0);
        chk("p_ferr", 32'(p_fcnt), 32'd0);

        // low stop bit then a held-low line: one frame_err only
        d_vcyc = 0; d_fcnt = 0;
        d_frame(8'h00, 1'b0);
        d_rx = 1'b0; tick(8 * 40);
        d_rx = 1'b1; tick(16);
        chk("brk_ferr", 32'(d_fcnt), 32'd1);
        chk("brk_valid", 32'(d_vcyc), 32'd0);
        d_q.push_back({1'b0, 8'hA3});
        d_frame(8'hA3, 1'b1);
        tick(16);
        chk("q_a3", 32'(d_q.size()), 32'd0);
        chk("data_a3", 32'(d_data), 32'hA3);

        // consumer stalled across three back-to-back frames
        d_ready = 1'b0;
        d_q.push_back({1'b0, 8'h11});
        d_frame(8'h11, 1'b1);
        d_frame(8'h22, 1'b1);
        d_frame(8'h33, 1'b1);
        tick(16);
        chk("ovr_data", 32'(d_data), 32'h11);
        chk("ovr_valid", 32'(d_valid), 32'h1);
        chk("ovr_set", 32'(d_ovr), 32'h1);
        d_eclr = 1'b1; tick(1);
        d_eclr = 1'b0;
        chk("ovr_clr", 32'(d_ovr), 32'h0);
        chk("ovr_valid_hold", 32'(d_valid), 32'h1);
        d_ready = 1'b1; tick(2);
        chk("ovr_drain", 32'(d_valid), 32'h0);
        chk("q_ovr", 32'(d_q.size()), 32'd0);

        // reset in the middle of data bit 3 of 0x7E
        d_bit(1'b0);
        d_bit(1'b0); d_bit(1'b1); d_bit(1'b1);
        d_rx = 1'b1; tick(4);
        rst_n = 1'b0;
        tick(2);
        chk("mid_rst_data", 32'(d_data), 32'h0);
        chk("mid_rst_valid", 32'(d_valid), 32'h0);
        chk("mid_rst_perr", 32'(d_perr), 32'h0);
        chk("mid_rst_ferr", 32'(d_ferr), 32'h0);
        chk("mid_rst_ovr", 32'(d_ovr), 32'h0);
        rst_n = 1'b1;
        tick(8);
        d_q.push_back({1'b0, 8'hC4});
        d_frame(8'hC4, 1'b1);
        tick(16);
        chk("data_c4", 32'(d_data), 32'hC4);
        chk("q_end", 32'(d_q.size()), 32'd0);
        chk("p_q_end", 32'(p_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
